// File: rtl/datapath_pipe.sv
// datapath_pipe: one-stage pipelined register-file/ALU datapath with writeback
// forwarding, a registered {V,C,N,Z} status word and a handshaked data-memory port.
// Optional build macro: DATAPATH_TIMEOUT_EN enables the memory watchdog and mem_err.
module datapath_pipe #(
    parameter int unsigned DATA_W      = 64,
    parameter int unsigned REG_ADDR_W  = 5,
    parameter int unsigned MEM_ADDR_W  = 32,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  op_valid,
    output logic                  op_ready,
    input  logic [REG_ADDR_W-1:0] sa,
    input  logic [REG_ADDR_W-1:0] sb,
    input  logic [REG_ADDR_W-1:0] da,
    input  logic [4:0]            fs,
    input  logic                  c_in,
    input  logic [DATA_W-1:0]     k,
    input  logic                  b_sel,
    input  logic [1:0]            d_sel,
    input  logic                  mem_wr,
    input  logic                  set_flags,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_ack,
    output logic                  wb_valid,
    output logic [REG_ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0]     wb_data,
    output logic [3:0]            status,
    output logic [DATA_W-1:0]     f_out,
    input  logic [REG_ADDR_W-1:0] dbg_sel,
    output logic [DATA_W-1:0]     dbg_data,
    output logic                  mem_err
);
    localparam int unsigned NUM_REGS = 2 ** REG_ADDR_W;
    localparam logic [REG_ADDR_W-1:0] XZR = REG_ADDR_W'(NUM_REGS - 1);
    localparam int unsigned SH_W  = $clog2(DATA_W);
    localparam int unsigned SUM_W = DATA_W + 1;

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_MEM_WAIT = 1'b1} state_t;

    logic [DATA_W-1:0]     r_regs [NUM_REGS];
    state_t                r_state, w_state_nxt;
    logic                  r_op_ready, w_op_ready_nxt;
    logic                  r_mem_req, w_mem_req_nxt;
    logic                  r_mem_we, w_mem_we_nxt;
    logic [MEM_ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
    logic [DATA_W-1:0]     r_mem_wdata, w_mem_wdata_nxt;
    logic                  r_wb_valid, w_wb_valid_nxt;
    logic [REG_ADDR_W-1:0] r_wb_addr, w_wb_addr_nxt;
    logic [DATA_W-1:0]     r_wb_data, w_wb_data_nxt;
    logic [3:0]            r_status, w_status_nxt;
    logic [REG_ADDR_W-1:0] r_ld_da, w_ld_da_nxt;

    logic [DATA_W-1:0]     w_a, w_b_reg, w_b, w_a_op, w_b_op, w_f;
    logic [SUM_W-1:0]      w_sum;
    logic                  w_c, w_v, w_accept;
    logic [3:0]            w_flags;

`ifdef DATAPATH_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
    logic                  r_mem_err, w_mem_err_nxt;
    assign mem_err = r_mem_err;
`else
    assign mem_err = 1'b0;
`endif

    assign w_accept  = r_op_ready & op_valid;
    assign op_ready  = r_op_ready;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign wb_valid  = r_wb_valid;
    assign wb_addr   = r_wb_addr;
    assign wb_data   = r_wb_data;
    assign status    = r_status;
    assign f_out     = w_f;
    assign dbg_data  = (dbg_sel == XZR) ? '0 : r_regs[dbg_sel];

    // Operand read: XZR reads zero, otherwise the pending writeback wins over the file
    always_comb begin
        w_a = r_regs[sa];
        if (sa == XZR)
            w_a = '0;
        else if (r_wb_valid && (r_wb_addr == sa))
            w_a = r_wb_data;
        w_b_reg = r_regs[sb];
        if (sb == XZR)
            w_b_reg = '0;
        else if (r_wb_valid && (r_wb_addr == sb))
            w_b_reg = r_wb_data;
        w_b = b_sel ? k : w_b_reg;
    end

    // ALU with optional operand inversion; carry/overflow only meaningful for ADD
    always_comb begin
        w_a_op = fs[0] ? ~w_a : w_a;
        w_b_op = fs[1] ? ~w_b : w_b;
        w_sum  = SUM_W'(w_a_op) + SUM_W'(w_b_op) + SUM_W'(c_in);
        w_f    = '0;
        w_c    = 1'b0;
        w_v    = 1'b0;
        case (fs[4:2])
            3'b000: w_f = w_a_op & w_b_op;
            3'b001: w_f = w_a_op | w_b_op;
            3'b010: begin
                w_f = w_sum[DATA_W-1:0];
                w_c = w_sum[DATA_W];
                w_v = (w_a_op[DATA_W-1] == w_b_op[DATA_W-1]) &&
                      (w_sum[DATA_W-1] != w_a_op[DATA_W-1]);
            end
            3'b011: w_f = w_a_op ^ w_b_op;
            3'b100: w_f = w_a_op << w_b_op[SH_W-1:0];
            3'b101: w_f = w_a_op >> w_b_op[SH_W-1:0];
            default: w_f = '0;
        endcase
        w_flags = {w_v, w_c, w_f[DATA_W-1], (w_f == '0)};
    end

    // Next-state and registered-output logic for the IDLE / MEM_WAIT controller
    always_comb begin
        w_state_nxt     = r_state;
        w_op_ready_nxt  = r_op_ready;
        w_mem_req_nxt   = r_mem_req;
        w_mem_we_nxt    = r_mem_we;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_wb_valid_nxt  = 1'b0;
        w_wb_addr_nxt   = r_wb_addr;
        w_wb_data_nxt   = r_wb_data;
        w_status_nxt    = r_status;
        w_ld_da_nxt     = r_ld_da;
`ifdef DATAPATH_TIMEOUT_EN
        w_cnt_nxt       = r_cnt;
        w_mem_err_nxt   = r_mem_err;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (set_flags)
                        w_status_nxt = w_flags;
                    if (mem_wr || (d_sel == 2'd2)) begin
                        w_state_nxt     = S_MEM_WAIT;
                        w_op_ready_nxt  = 1'b0;
                        w_mem_req_nxt   = 1'b1;
                        w_mem_we_nxt    = mem_wr;
                        w_mem_addr_nxt  = w_f[MEM_ADDR_W-1:0];
                        w_mem_wdata_nxt = w_b;
                        w_ld_da_nxt     = da;
`ifdef DATAPATH_TIMEOUT_EN
                        w_cnt_nxt       = '0;
`endif
                    end else if (d_sel != 2'd3) begin
                        w_wb_valid_nxt = 1'b1;
                        w_wb_addr_nxt  = da;
                        w_wb_data_nxt  = (d_sel == 2'd0) ? w_f : w_b;
                    end
                end
            end
            S_MEM_WAIT: begin
                if (mem_ack) begin
                    w_state_nxt    = S_IDLE;
                    w_op_ready_nxt = 1'b1;
                    w_mem_req_nxt  = 1'b0;
                    if (!r_mem_we) begin
                        w_wb_valid_nxt = 1'b1;
                        w_wb_addr_nxt  = r_ld_da;
                        w_wb_data_nxt  = mem_rdata;
                    end
                end
`ifdef DATAPATH_TIMEOUT_EN
                else if (r_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                    w_state_nxt    = S_IDLE;
                    w_op_ready_nxt = 1'b1;
                    w_mem_req_nxt  = 1'b0;
                    w_mem_err_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
`endif
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Controller state and output registers
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_op_ready  <= 1'b1;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_wb_valid  <= 1'b0;
            r_wb_addr   <= '0;
            r_wb_data   <= '0;
            r_status    <= '0;
            r_ld_da     <= '0;
`ifdef DATAPATH_TIMEOUT_EN
            r_cnt       <= '0;
            r_mem_err   <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_op_ready  <= w_op_ready_nxt;
            r_mem_req   <= w_mem_req_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_wb_valid  <= w_wb_valid_nxt;
            r_wb_addr   <= w_wb_addr_nxt;
            r_wb_data   <= w_wb_data_nxt;
            r_status    <= w_status_nxt;
            r_ld_da     <= w_ld_da_nxt;
`ifdef DATAPATH_TIMEOUT_EN
            r_cnt       <= w_cnt_nxt;
            r_mem_err   <= w_mem_err_nxt;
`endif
        end
    end

    // Register file: architectural write one edge after the writeback stage
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < int'(NUM_REGS); i++)
                r_regs[i] <= '0;
        end else if (r_wb_valid && (r_wb_addr != XZR)) begin
            r_regs[r_wb_addr] <= r_wb_data;
        end
    end

endmodule
